// File: rtl/uart_cmd_decoder_if.sv
// ---------------------------------------------------------------------------
// uart_cmd_decoder_if
//   Bundles the byte stream from the UART receiver, the controller busy flag
//   and the decoded command outputs of uart_cmd_decoder.
//
//   Signals:
//     rx_data    [7:0]  received byte, qualified by rx_valid
//     rx_valid          single-cycle byte strobe
//     ctrlr_busy        controller busy; a command is issued only when low
//     cmd        [3:0]  decoded function code
//     addr       [31:0] operand address
//     data       [31:0] write data
//     out_valid         one-cycle command-valid pulse
//     frame_err         one-cycle pulse when a frame is dropped
//     rx_overrun        one-cycle pulse when a byte is discarded
//
//   Modports:
//     master : the decoder (consumes bytes, produces commands)
//     slave  : the environment (UART receiver + controller side)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface uart_cmd_decoder_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        ctrlr_busy;
    logic [3:0]  cmd;
    logic [31:0] addr;
    logic [31:0] data;
    logic        out_valid;
    logic        frame_err;
    logic        rx_overrun;

    modport master (
        input  rx_data, rx_valid, ctrlr_busy,
        output cmd, addr, data, out_valid, frame_err, rx_overrun
    );

    modport slave (
        output rx_data, rx_valid, ctrlr_busy,
        input  cmd, addr, data, out_valid, frame_err, rx_overrun
    );
endinterface

// File: rtl/uart_cmd_decoder.sv
// ---------------------------------------------------------------------------
// uart_cmd_decoder
//   Assembles UART bytes into a debugger command (4-bit code, optional 32-bit
//   address, optional 32-bit write data) and hands it to the controller with
//   a one-cycle out_valid pulse once the controller is not busy. Malformed or
//   stalled frames are dropped with a frame_err pulse; bytes arriving while a
//   command is pending are dropped with an rx_overrun pulse.
//
//   Parameters:
//     TIMEOUT_CYCLES : max idle cycles between bytes of one frame (>= 2)
//
//   Ports:
//     clk   : system clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : uart_cmd_decoder_if.master (byte input, busy, command outputs)
//
//   Build option:
//     UART_CMD_CHECKSUM_EN : when defined, every frame carries a trailing XOR
//                            checksum byte checked in state S_CSUM.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_cmd_decoder #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_cmd_decoder_if.master bus
);

    localparam int                TCNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_CMD,
        S_OPER,
`ifdef UART_CMD_CHECKSUM_EN
        S_CSUM,
`endif
        S_WAIT,
        S_ISSUE
    } state_t;

    // Number of operand bytes that follow a given function code.
    function automatic logic [3:0] oper_count(input logic [3:0] code);
        if (code <= 4'h5)      return 4'd0;
        else if (code <= 4'hA) return 4'd4;
        else                   return 4'd8;
    endfunction

    state_t            r_state;
    logic [3:0]        r_cmd;
    logic [31:0]       r_addr;
    logic [31:0]       r_data;
    logic [2:0]        r_opcnt;
    logic [TCNT_W-1:0] r_tcnt;
    logic              r_out_valid;
    logic              r_frame_err;
    logic              r_rx_overrun;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]        r_csum;
`endif

    logic       w_cmd_legal;
    logic [3:0] w_new_n;
    logic       w_last_oper;
    logic       w_tmo;

    assign w_cmd_legal = (bus.rx_data[7:4] == 4'h0) &&
                         (bus.rx_data[3:0] >= 4'h1) &&
                         (bus.rx_data[3:0] <= 4'hD);
    assign w_new_n     = oper_count(bus.rx_data[3:0]);
    // Only evaluated in S_OPER, where the count is 4 or 8, so no underflow.
    assign w_last_oper = ({1'b0, r_opcnt} == (oper_count(r_cmd) - 4'd1));
    // The counter would reach TIMEOUT_CYCLES at this edge; a byte in the
    // same cycle takes priority.
    assign w_tmo       = (r_tcnt == TCNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_CMD;
            r_cmd        <= 4'h0;
            r_addr       <= 32'h0;
            r_data       <= 32'h0;
            r_opcnt      <= 3'd0;
            r_tcnt       <= '0;
            r_out_valid  <= 1'b0;
            r_frame_err  <= 1'b0;
            r_rx_overrun <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
            r_csum       <= 8'h00;
`endif
        end else begin
            // NOTE: pulses default low here and are overridden below; with
            // non-blocking assignments the last write in the block wins, so
            // every pulse is exactly one cycle without extra clear logic.
            r_out_valid  <= 1'b0;
            r_frame_err  <= 1'b0;
            r_rx_overrun <= 1'b0;

            case (r_state)
                S_CMD: begin
                    if (bus.rx_valid) begin
                        if (!w_cmd_legal) begin
                            r_frame_err <= 1'b1;
                        end else begin
                            r_cmd   <= bus.rx_data[3:0];
                            r_addr  <= 32'h0;
                            r_data  <= 32'h0;
                            r_opcnt <= 3'd0;
                            r_tcnt  <= '0;
`ifdef UART_CMD_CHECKSUM_EN
                            r_csum  <= bus.rx_data;
                            r_state <= (w_new_n == 4'd0) ? S_CSUM : S_OPER;
`else
                            r_state <= (w_new_n == 4'd0) ? S_WAIT : S_OPER;
`endif
                        end
                    end
                end

                S_OPER: begin
                    if (bus.rx_valid) begin
                        r_tcnt <= '0;
                        // Bytes 0-3 build the address, bytes 4-7 the data.
                        if (!r_opcnt[2]) r_addr <= {r_addr[23:0], bus.rx_data};
                        else             r_data <= {r_data[23:0], bus.rx_data};
                        r_opcnt <= r_opcnt + 3'd1;
`ifdef UART_CMD_CHECKSUM_EN
                        r_csum  <= r_csum ^ bus.rx_data;
                        if (w_last_oper) r_state <= S_CSUM;
`else
                        if (w_last_oper) r_state <= S_WAIT;
`endif
                    end else if (w_tmo) begin
                        r_frame_err <= 1'b1;
                        r_tcnt      <= '0;
                        r_state     <= S_CMD;
                    end else begin
                        r_tcnt <= r_tcnt + TCNT_W'(1);
                    end
                end

`ifdef UART_CMD_CHECKSUM_EN
                S_CSUM: begin
                    if (bus.rx_valid) begin
                        r_tcnt <= '0;
                        if (bus.rx_data == r_csum) begin
                            r_state <= S_WAIT;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_CMD;
                        end
                    end else if (w_tmo) begin
                        r_frame_err <= 1'b1;
                        r_tcnt      <= '0;
                        r_state     <= S_CMD;
                    end else begin
                        r_tcnt <= r_tcnt + TCNT_W'(1);
                    end
                end
`endif

                S_WAIT: begin
                    if (bus.rx_valid) r_rx_overrun <= 1'b1;
                    // out_valid is set on the transition so it is high for
                    // exactly the cycle spent in S_ISSUE.
                    if (!bus.ctrlr_busy) begin
                        r_out_valid <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (bus.rx_valid) r_rx_overrun <= 1'b1;
                    r_state <= S_CMD;
                end

                default: r_state <= S_CMD;
            endcase
        end
    end

    assign bus.cmd        = r_cmd;
    assign bus.addr       = r_addr;
    assign bus.data       = r_data;
    assign bus.out_valid  = r_out_valid;
    assign bus.frame_err  = r_frame_err;
    assign bus.rx_overrun = r_rx_overrun;

endmodule
